// File: rtl/reu_pkg.sv
// REU DMA sequencer shared definitions.
// Contents: transfer mode encodings, sequencer state enum and address widths.
// No ports.
package reu_pkg;

    localparam int unsigned REU_AW = 24;
    localparam int unsigned C64_AW = 16;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic [1:0] {
        MODE_STASH  = 2'b00,
        MODE_FETCH  = 2'b01,
        MODE_SWAP   = 2'b10,
        MODE_VERIFY = 2'b11
    } reu_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StXfer,
        StSwapw,
        StDrain
    } reu_state_e;

endpackage

// File: rtl/phi2_edge.sv
// PHI2 synchronizer and falling-edge detector in the C8M domain.
// Ports:
//   i_clk   - C8M dot clock
//   i_rst_n - asynchronous active-low reset
//   i_phi2  - raw C64 PHI2
//   o_fall  - one-C8M pulse after a synchronized PHI2 falling edge
module phi2_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_phi2,
    output logic o_fall
);

    logic r_sync0;
    logic r_sync1;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync0 <= i_phi2;
            r_sync1 <= r_sync0;
            r_prev  <= r_sync1;
        end
    end

    // Built from flops only, so the pulse is glitch-free.
    assign o_fall = r_prev & ~r_sync1;

endmodule

// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: runs one programmed stash/fetch/swap/verify transfer,
// one byte per PHI2 slot, stealing the C64 bus and commanding the SDRAM controller.
// Ports:
//   i_c8m, i_nreset          - dot clock, async active-low reset
//   i_phi2, i_ba             - C64 PHI2 and bus-available
//   i_start, i_mode          - transfer start pulse and mode
//   i_caddr/i_raddr/i_len    - C64 start, REU start, byte count (0 = 65536)
//   i_fixc/i_fixr            - hold C64 / REU address constant
//   i_rdd, i_cdi             - SDRAM read data, C64 data in
//   o_ndma, o_ca, o_caoe, o_crw, o_cdo, o_cdoe - C64 bus side
//   o_rdcmd, o_wrcmd, o_a    - SDRAM controller commands and address
//   o_busy, o_eob, o_fault   - status (eob/fault sticky until next start)
//   o_ccur, o_rcur, o_lcur   - live counters
// Build option: GW_REU_AUTOLOAD_EN reloads the start values into the counters
// when a transfer ends.
module reu_dma_seq
    import reu_pkg::*;
(
    input  logic              i_c8m,
    input  logic              i_nreset,
    input  logic              i_phi2,
    input  logic              i_ba,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [C64_AW-1:0] i_caddr,
    input  logic [REU_AW-1:0] i_raddr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_fixc,
    input  logic              i_fixr,
    input  logic [7:0]        i_rdd,
    input  logic [7:0]        i_cdi,
    output logic              o_ndma,
    output logic [C64_AW-1:0] o_ca,
    output logic              o_caoe,
    output logic              o_crw,
    output logic [7:0]        o_cdo,
    output logic              o_cdoe,
    output logic              o_rdcmd,
    output logic              o_wrcmd,
    output logic [REU_AW-1:0] o_a,
    output logic              o_busy,
    output logic              o_eob,
    output logic              o_fault,
    output logic [C64_AW-1:0] o_ccur,
    output logic [REU_AW-1:0] o_rcur,
    output logic [LEN_W-1:0]  o_lcur
);

    reu_state_e        r_state;
    reu_mode_e         r_mode;
    logic              r_fixc, r_fixr;
    logic [C64_AW-1:0] r_ccur;
    logic [REU_AW-1:0] r_rcur;
    logic [LEN_W-1:0]  r_lcur;
    logic [REU_AW-1:0] r_rprev;   // REU address of the stash byte awaiting its WRCMD
    logic              r_pend;    // a stash byte is waiting to be written
    logic              r_act;     // current slot is a real (non-frozen) access
    logic [7:0]        r_rbyte;   // REU byte held across a swap stall
    logic              r_ndma, r_caoe, r_crw, r_cdoe, r_rdcmd, r_wrcmd;
    logic              r_busy, r_eob, r_fault;
    logic [C64_AW-1:0] r_ca;
    logic [REU_AW-1:0] r_a;
    logic [7:0]        r_cdo;
`ifdef GW_REU_AUTOLOAD_EN
    logic [C64_AW-1:0] r_c0;
    logic [REU_AW-1:0] r_r0;
    logic [LEN_W-1:0]  r_l0;
`endif

    logic              w_fall;
    reu_state_e        w_nstate;
    logic              w_adv, w_eob, w_fault, w_swlatch, w_go, w_pend, w_last;
    logic [C64_AW-1:0] w_cnext, w_cslot;
    logic [REU_AW-1:0] w_rnext, w_rslot, w_pslot;
    logic [LEN_W-1:0]  w_lnext;

    phi2_edge u_phi2_edge (
        .i_clk   (i_c8m),
        .i_rst_n (i_nreset),
        .i_phi2  (i_phi2),
        .o_fall  (w_fall)
    );

    assign w_cnext = r_ccur + {{(C64_AW-1){1'b0}}, ~r_fixc};
    assign w_rnext = r_rcur + {{(REU_AW-1){1'b0}}, ~r_fixr};
    assign w_lnext = r_lcur - 1'b1;
    assign w_last  = (r_lcur == 16'd1);

    // Addresses for the slot that starts at this boundary, after any counter step.
    assign w_cslot = w_adv ? w_cnext : r_ccur;
    assign w_rslot = w_adv ? w_rnext : r_rcur;
    assign w_pslot = w_adv ? r_rcur : r_rprev;
    assign w_pend  = r_pend | w_adv;
    assign w_go    = i_ba & (w_nstate != StArm);

    // Close out the slot that ends at this boundary.
    always_comb begin
        w_nstate  = r_state;
        w_adv     = 1'b0;
        w_eob     = 1'b0;
        w_fault   = 1'b0;
        w_swlatch = 1'b0;
        case (r_state)
            StArm:   w_nstate = i_ba ? StXfer : StArm;
            StXfer: if (r_act) begin
                case (r_mode)
                    MODE_SWAP: begin
                        w_swlatch = 1'b1;
                        w_nstate  = StSwapw;
                    end
                    MODE_VERIFY: if (i_cdi != i_rdd) begin
                        w_fault  = 1'b1;
                        w_nstate = StIdle;
                    end else begin
                        w_adv = 1'b1;
                        if (w_last) begin
                            w_eob    = 1'b1;
                            w_nstate = StIdle;
                        end
                    end
                    MODE_STASH: begin
                        w_adv = 1'b1;
                        if (w_last) w_nstate = StDrain;
                    end
                    default: begin
                        w_adv = 1'b1;
                        if (w_last) begin
                            w_eob    = 1'b1;
                            w_nstate = StIdle;
                        end
                    end
                endcase
            end
            StSwapw: if (r_act) begin
                w_adv    = 1'b1;
                w_nstate = StXfer;
                if (w_last) begin
                    w_eob    = 1'b1;
                    w_nstate = StIdle;
                end
            end
            StDrain: if (r_act) begin
                w_eob    = 1'b1;
                w_nstate = StIdle;
            end
            default: w_nstate = r_state;
        endcase
    end

    always_ff @(posedge i_c8m or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state <= StIdle;
            r_mode  <= MODE_STASH;
            r_fixc  <= 1'b0;
            r_fixr  <= 1'b0;
            r_ccur  <= '0;
            r_rcur  <= '0;
            r_lcur  <= '0;
            r_rprev <= '0;
            r_pend  <= 1'b0;
            r_act   <= 1'b0;
            r_rbyte <= '0;
            r_ndma  <= 1'b1;
            r_caoe  <= 1'b0;
            r_crw   <= 1'b1;
            r_cdoe  <= 1'b0;
            r_rdcmd <= 1'b0;
            r_wrcmd <= 1'b0;
            r_busy  <= 1'b0;
            r_eob   <= 1'b0;
            r_fault <= 1'b0;
            r_ca    <= '0;
            r_a     <= '0;
            r_cdo   <= '0;
`ifdef GW_REU_AUTOLOAD_EN
            r_c0    <= '0;
            r_r0    <= '0;
            r_l0    <= '0;
`endif
        end else begin
            // Fetch data follows the SDRAM read data through the slot.
            if (r_state == StXfer && r_act && r_mode == MODE_FETCH) r_cdo <= i_rdd;
            if (r_state == StIdle) begin
                if (i_start) begin
                    r_state <= StArm;
                    r_mode  <= reu_mode_e'(i_mode);
                    r_fixc  <= i_fixc;
                    r_fixr  <= i_fixr;
                    r_ccur  <= i_caddr;
                    r_rcur  <= i_raddr;
                    r_lcur  <= i_len;
`ifdef GW_REU_AUTOLOAD_EN
                    r_c0    <= i_caddr;
                    r_r0    <= i_raddr;
                    r_l0    <= i_len;
`endif
                    r_busy  <= 1'b1;
                    r_ndma  <= 1'b0;
                    r_eob   <= 1'b0;
                    r_fault <= 1'b0;
                    r_pend  <= 1'b0;
                    r_act   <= 1'b0;
                end
            end else if (w_fall) begin
                if (w_adv) begin
                    r_ccur <= w_cnext;
                    r_rcur <= w_rnext;
                    r_lcur <= w_lnext;
                end
                if (w_adv && r_mode == MODE_STASH) begin
                    r_rprev <= r_rcur;
                    r_pend  <= 1'b1;
                end
                // The SDRAM controller captures the C64 byte itself; only the REU byte is kept.
                if (w_swlatch) r_rbyte <= i_rdd;
                if (w_eob) r_eob <= 1'b1;
                if (w_fault) r_fault <= 1'b1;
                r_state <= w_nstate;
                r_act   <= w_go;
                r_caoe  <= 1'b0;
                r_cdoe  <= 1'b0;
                r_crw   <= 1'b1;
                r_rdcmd <= 1'b0;
                r_wrcmd <= 1'b0;
                if (w_nstate == StIdle) begin
                    r_busy <= 1'b0;
                    r_ndma <= 1'b1;
`ifdef GW_REU_AUTOLOAD_EN
                    r_ccur <= r_c0;
                    r_rcur <= r_r0;
                    r_lcur <= r_l0;
`endif
                end else if (w_go) begin
                    case (w_nstate)
                        StXfer: begin
                            r_caoe <= 1'b1;
                            r_ca   <= w_cslot;
                            case (r_mode)
                                MODE_STASH: begin
                                    r_wrcmd <= w_pend;
                                    r_a     <= w_pslot;
                                end
                                MODE_FETCH: begin
                                    r_crw   <= 1'b0;
                                    r_cdoe  <= 1'b1;
                                    r_rdcmd <= 1'b1;
                                    r_a     <= w_rslot;
                                end
                                default: begin
                                    r_rdcmd <= 1'b1;
                                    r_a     <= w_rslot;
                                end
                            endcase
                        end
                        StSwapw: begin
                            r_caoe  <= 1'b1;
                            r_ca    <= r_ccur;
                            r_crw   <= 1'b0;
                            r_cdoe  <= 1'b1;
                            r_cdo   <= w_swlatch ? i_rdd : r_rbyte;
                            r_wrcmd <= 1'b1;
                            r_a     <= r_rcur;
                        end
                        StDrain: begin
                            r_wrcmd <= 1'b1;
                            r_a     <= w_pslot;
                        end
                        default: r_act <= w_go;
                    endcase
                end
            end
        end
    end

    assign o_ndma  = r_ndma;
    assign o_ca    = r_ca;
    assign o_caoe  = r_caoe;
    assign o_crw   = r_crw;
    assign o_cdo   = r_cdo;
    assign o_cdoe  = r_cdoe;
    assign o_rdcmd = r_rdcmd;
    assign o_wrcmd = r_wrcmd;
    assign o_a     = r_a;
    assign o_busy  = r_busy;
    assign o_eob   = r_eob;
    assign o_fault = r_fault;
    assign o_ccur  = r_ccur;
    assign o_rcur  = r_rcur;
    assign o_lcur  = r_lcur;

endmodule

// File: tb/tb_reu_dma_seq.sv
// Directed testbench for reu_dma_seq with small C64 and SDRAM memory models.
module tb_reu_dma_seq;

    logic        c8m = 1'b0;
    logic        nreset, phi2, ba, start, fixc, fixr;
    logic [1:0]  mode;
    logic [15:0] caddr, len;
    logic [23:0] raddr;
    logic [7:0]  rdd, cdi;
    logic        ndma, caoe, crw, cdoe, rdcmd, wrcmd, busy, eob, fault;
    logic [15:0] ca, ccur, lcur;
    logic [23:0] a, rcur;
    logic [7:0]  cdo;

    logic [7:0]  c64_mem [0:255];
    logic [7:0]  reu_mem [0:255];
    logic [7:0]  c64_latch;
    int          n_chk = 0;
    int          n_err = 0;

    reu_dma_seq u_dut (
        .i_c8m(c8m), .i_nreset(nreset), .i_phi2(phi2), .i_ba(ba), .i_start(start),
        .i_mode(mode), .i_caddr(caddr), .i_raddr(raddr), .i_len(len),
        .i_fixc(fixc), .i_fixr(fixr), .i_rdd(rdd), .i_cdi(cdi),
        .o_ndma(ndma), .o_ca(ca), .o_caoe(caoe), .o_crw(crw), .o_cdo(cdo), .o_cdoe(cdoe),
        .o_rdcmd(rdcmd), .o_wrcmd(wrcmd), .o_a(a), .o_busy(busy), .o_eob(eob),
        .o_fault(fault), .o_ccur(ccur), .o_rcur(rcur), .o_lcur(lcur)
    );

    always #5 c8m = ~c8m;

    // PHI2: 4 C8M cycles high, 4 low, changing away from the C8M active edge.
    initial begin
        phi2 = 1'b1;
        forever begin
            repeat (4) @(negedge c8m);
            phi2 = ~phi2;
        end
    end

    // Memories indexed by the low address byte; tests use disjoint regions.
    assign rdd = reu_mem[a[7:0]];
    assign cdi = c64_mem[ca[7:0]];

    // SDRAM controller writes the C64 byte captured at the previous PHI2 fall.
    always @(negedge phi2) begin
        if (wrcmd) reu_mem[a[7:0]] = c64_latch;
        if (caoe && crw) c64_latch = cdi;
        if (caoe && cdoe && !crw) c64_mem[ca[7:0]] = cdo;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ndma"}, 32'(ndma), 32'h1);
        check({pfx, "_caoe"}, 32'(caoe), 32'h0);
        check({pfx, "_cdoe"}, 32'(cdoe), 32'h0);
        check({pfx, "_crw"}, 32'(crw), 32'h1);
        check({pfx, "_cmds"}, 32'({rdcmd, wrcmd}), 32'h0);
        check({pfx, "_a"}, 32'(a), 32'h0);
        check({pfx, "_ca"}, 32'(ca), 32'h0);
        check({pfx, "_cdo"}, 32'(cdo), 32'h0);
        check({pfx, "_stat"}, 32'({busy, eob, fault}), 32'h0);
        check({pfx, "_ccur"}, 32'(ccur), 32'h0);
        check({pfx, "_rcur"}, 32'(rcur), 32'h0);
        check({pfx, "_lcur"}, 32'(lcur), 32'h0);
    endtask

    task automatic start_xfer(input logic [1:0] m, input logic [15:0] c, input logic [23:0] r,
                              input logic [15:0] l, input logic fc);
        @(posedge phi2);
        @(negedge c8m);
        mode = m; caddr = c; raddr = r; len = l; fixc = fc; fixr = 1'b0;
        start = 1'b1;
        @(negedge c8m);
        start = 1'b0;
        #1;
    endtask

    task automatic next_slot();
        @(posedge phi2);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            c64_mem[i] = 8'h00;
            reu_mem[i] = 8'h00;
        end
        c64_latch = 8'h00;
        nreset = 1'b0; ba = 1'b1; start = 1'b0; mode = 2'b00;
        caddr = '0; raddr = '0; len = '0; fixc = 1'b0; fixr = 1'b0;
        repeat (3) @(negedge c8m);
        check_reset_vals("reset");
        nreset = 1'b1;

        // Stash 3 bytes C000 -> 000100.
        c64_mem[8'h00] = 8'h11; c64_mem[8'h01] = 8'h22; c64_mem[8'h02] = 8'h33;
        start_xfer(2'b00, 16'hC000, 24'h000100, 16'd3, 1'b0);
        check("arm_ndma", 32'(ndma), 32'h0);
        check("arm_busy", 32'(busy), 32'h1);
        check("arm_caoe", 32'(caoe), 32'h0);
        next_slot();
        check("st1_rd", 32'({caoe, crw, wrcmd}), 32'b110);
        check("st1_ca", 32'(ca), 32'hC000);
        next_slot();
        check("st2_wr", 32'({wrcmd, a}), 32'h1000100);
        check("st2_ca", 32'(ca), 32'hC001);
        next_slot();
        check("st3_wr", 32'({wrcmd, a}), 32'h1000101);
        check("st3_ca", 32'(ca), 32'hC002);
        next_slot();
        check("st4_drain", 32'({wrcmd, a}), 32'h1000102);
        check("st4_caoe", 32'({caoe, busy}), 32'b01);
        next_slot();
        check("st_end_stat", 32'({busy, eob, fault, ndma, wrcmd}), 32'b01010);
        check("st_ccur", 32'(ccur), 32'hC003);
        check("st_rcur", 32'(rcur), 32'h000103);
        check("st_lcur", 32'(lcur), 32'h0);
        check("st_reu", 32'({reu_mem[8'h00], reu_mem[8'h01], reu_mem[8'h02]}), 32'h112233);

        // Fetch 2 bytes to fixed D020.
        reu_mem[8'h00] = 8'h5A; reu_mem[8'h01] = 8'hA5;
        start_xfer(2'b01, 16'hD020, 24'h000200, 16'd2, 1'b1);
        check("fe_eob_clr", 32'(eob), 32'h0);
        next_slot();
        check("fe1_cmd", 32'({rdcmd, crw, cdoe, a}), 32'h5000200);
        check("fe1_data", 32'({ca, cdo}), 32'hD0205A);
        next_slot();
        check("fe2_cmd", 32'({rdcmd, a}), 32'h1000201);
        check("fe2_data", 32'({ca, cdo}), 32'hD020A5);
        next_slot();
        check("fe_end", 32'({busy, eob, rdcmd, cdoe}), 32'b0100);
        check("fe_rcur", 32'(rcur), 32'h000202);
        check("fe_ccur", 32'(ccur), 32'hD020);
        check("fe_c64", 32'(c64_mem[8'h20]), 32'hA5);

        // Swap 1 byte: C64 AA <-> REU 55.
        c64_mem[8'h40] = 8'hAA; reu_mem[8'h30] = 8'h55;
        start_xfer(2'b10, 16'hC040, 24'h000330, 16'd1, 1'b0);
        next_slot();
        check("sw1", 32'({rdcmd, wrcmd, crw, caoe, a}), 32'hB000330);
        check("sw1_ca", 32'(ca), 32'hC040);
        next_slot();
        check("sw2", 32'({rdcmd, wrcmd, crw, cdoe, a}), 32'h5000330);
        check("sw2_cdo", 32'({ca, cdo}), 32'hC04055);
        next_slot();
        check("sw_end", 32'({busy, eob}), 32'b01);
        check("sw_mem", 32'({c64_mem[8'h40], reu_mem[8'h30]}), 32'h55AA);
        check("sw_cur", 32'({ccur, rcur[15:0]}), 32'hC0410331);

        // Verify 4 bytes with a mismatch at byte 2.
        for (int i = 0; i < 4; i++) begin
            c64_mem[8'h80 + i] = 8'(i + 1);
            reu_mem[8'h80 + i] = 8'(i + 1);
        end
        reu_mem[8'h82] = 8'hFF;
        start_xfer(2'b11, 16'hC080, 24'h000080, 16'd4, 1'b0);
        next_slot();
        check("vf1", 32'({rdcmd, crw, a}), 32'h3000080);
        next_slot();
        check("vf2", 32'({rdcmd, a}), 32'h1000081);
        next_slot();
        check("vf3", 32'({rdcmd, a}), 32'h1000082);
        next_slot();
        check("vf4_nocmd", 32'({rdcmd, caoe}), 32'b00);
        check("vf_stat", 32'({busy, eob, fault, ndma}), 32'b0011);
        check("vf_lcur", 32'(lcur), 32'h2);
        check("vf_cur", 32'({ccur, rcur[15:0]}), 32'hC0820082);

        // Stash across the REU address wrap.
        c64_mem[8'hA0] = 8'h66; c64_mem[8'hA1] = 8'h77;
        start_xfer(2'b00, 16'hC0A0, 24'hFFFFFF, 16'd2, 1'b0);
        check("wr_fault_clr", 32'(fault), 32'h0);
        next_slot();
        next_slot();
        check("wr2", 32'({wrcmd, a}), 32'h1FFFFFF);
        next_slot();
        check("wr3", 32'({wrcmd, a}), 32'h1000000);
        next_slot();
        check("wr_rcur", 32'(rcur), 32'h000001);
        check("wr_eob", 32'({busy, eob}), 32'b01);
        check("wr_reu", 32'({reu_mem[8'hFF], reu_mem[8'h00]}), 32'h6677);

        // Fetch 3 bytes with BA low for three slots after the first byte.
        reu_mem[8'h40] = 8'hC1; reu_mem[8'h41] = 8'hC2; reu_mem[8'h42] = 8'hC3;
        start_xfer(2'b01, 16'hC0C0, 24'h000040, 16'd3, 1'b0);
        next_slot();
        check("ba1", 32'({rdcmd, a[7:0], cdo}), 32'h140C1);
        ba = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_slot();
            check("ba_frozen", 32'({rdcmd, caoe, cdoe, busy}), 32'b0001);
            check("ba_ctr", 32'({rcur[7:0], lcur}), 32'h410002);
        end
        ba = 1'b1;
        next_slot();
        check("ba_resume", 32'({rdcmd, a[7:0], cdo}), 32'h141C2);
        check("ba_resume_ca", 32'(ca), 32'hC0C1);
        next_slot();
        check("ba_last", 32'({rdcmd, a[7:0], cdo}), 32'h142C3);
        next_slot();
        check("ba_end", 32'({busy, eob, lcur}), 32'h10000);
        check("ba_c64", 32'({c64_mem[8'hC0], c64_mem[8'hC1], c64_mem[8'hC2]}), 32'hC1C2C3);

        // LEN=0 means 65536: counter wraps downward and the transfer keeps going.
        start_xfer(2'b00, 16'hC000, 24'h000000, 16'd0, 1'b0);
        next_slot();
        check("l0_s1", 32'({busy, lcur}), 32'h10000);
        next_slot();
        check("l0_s2", 32'({busy, wrcmd, lcur}), 32'h3FFFF);
        next_slot();
        check("l0_s3", 32'({busy, lcur}), 32'h1FFFE);
        nreset = 1'b0;
        repeat (2) @(negedge c8m);
        nreset = 1'b1;

        // Reset pulse in the middle of a swap write slot.
        start_xfer(2'b10, 16'hC050, 24'h000050, 16'd2, 1'b0);
        next_slot();
        next_slot();
        check("rs_swapw", 32'({wrcmd, cdoe, ndma}), 32'b110);
        nreset = 1'b0;
        #1;
        check_reset_vals("midswap");
        repeat (2) @(negedge c8m);
        nreset = 1'b1;
        next_slot();
        check("rs_idle", 32'({busy, ndma, caoe}), 32'b010);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/reu_dma_seq.md
# reu_dma_seq

DMA sequencer for the cartridge's REU engine. It accepts a transfer programmed by the register file and then runs it one byte per PHI2 cycle: it steals the C64 bus via /DMA and drives the C64 address and direction, and it issues RDCMD/WRCMD with a 24-bit REU address to the SDRAM controller. It supports stash, fetch, swap and verify transfers and reports end-of-block and verify-fault status.

## Interface
- No parameters; widths fixed by REU register map.
- C8M  in  1  dot clock, all logic on posedge.
- nRESET  in  1  asynchronous active-low reset.
- PHI2  in  1  C64 PHI2, sampled on C8M.
- BA  in  1  C64 bus available; high = DMA slot usable.
- START  in  1  one-C8M pulse from register file.
- MODE  in  2  00 stash (C64→REU), 01 fetch (REU→C64), 10 swap, 11 verify.
- CADDR  in  16  C64 start address.
- RADDR  in  24  REU start address.
- LEN  in  16  byte count; 0 means 65536.
- FIXC, FIXR  in  1 each  hold C64 / REU address constant.
- RDD  in  8  read data from SDRAM controller, valid from S4 of the slot.
- CDI  in  8  C64 data bus input.
- nDMA  out  1  C64 /DMA, open-drain intent.
- CA  out  16  C64 address; CAOE  out  1  address drive enable.
- CRW  out  1  C64 R/W (1 = read).
- CDO  out  8  C64 write data; CDOE  out  1  data drive enable.
- RDCMD, WRCMD  out  1 each  SDRAM controller commands, held a whole slot.
- A  out  24  REU address to SDRAM controller.
- BUSY, EOB, FAULT  out  1 each  status; EOB/FAULT sticky until next START.
- CCUR  out  16; RCUR  out  24; LCUR  out  16  live counters for readback.

## Operation
- Slot = one PHI2 cycle, beginning at the C8M edge after a PHI2 falling edge is detected. Outputs change only at slot boundaries.
- States: IDLE → ARM (nDMA=0, wait for BA=1 at a slot boundary) → XFER → [SWAPW for swap] → DRAIN → IDLE.
- START in IDLE loads CCUR/RCUR/LCUR and enters ARM; START outside IDLE ignored.
- Stash: slot k: C64 read at byte k (CRW=1, CAOE=1); WRCMD with A = address of byte k−1 (the SDRAM controller latches C64 data at the PHI2 fall). Final byte's WRCMD issued in DRAIN.
- Fetch: slot k: RDCMD at byte k; CRW=0, CDOE=1, CDO=RDD from S4 onward.
- Swap: two slots per byte: XFER = RDCMD + C64 read (latch CDI and RDD); SWAPW = WRCMD (REU gets C64 byte) + C64 write of the REU byte.
- Verify: RDCMD + C64 read per slot; compare at PHI2 fall; mismatch sets FAULT and ends the transfer immediately (DRAIN skipped, no further commands).
- After each byte: CCUR += !FIXC, RCUR += !FIXR (24-bit wrap, FFFFFF→000000), LCUR −= 1 (16-bit, 0 start = 65536). LCUR reaching 1 at a byte completion marks the last byte; EOB is set when the state returns to IDLE.
- BA low at a slot boundary: freeze the slot (no RDCMD/WRCMD, CAOE=CDOE=0, counters held) and retry it at the first boundary with BA=1. For swap, a stall between XFER and SWAPW keeps the latched bytes.

## Timing
- Reset (async) values: nDMA=1, CAOE=CDOE=0, CRW=1, RDCMD=WRCMD=0, A=0, CA=0, CDO=0, BUSY=EOB=FAULT=0, all counters 0, state IDLE.
- Reset mid-transfer releases the bus within the assertion; no partial command persists.
- First C64 access happens no earlier than the second slot after START (ARM plus one BA=1 boundary).
- Stash N bytes = N+1 slots; fetch and verify = N slots; swap = 2N slots (excluding stalls).
- BUSY=1 from START+1 C8M until entry into IDLE.

## Configuration
- GW_REU_AUTOLOAD_EN defined: at transfer end (EOB or FAULT), CCUR/RCUR/LCUR reload the start values captured at START.
- Undefined: counters keep their final values.

## Structure
- Package reu_pkg: MODE encodings (MODE_STASH…MODE_VERIFY), state enum, width constants (REU_AW=24, C64_AW=16).
- One sub-module phi2_edge: two-stage synchronizer plus fall-pulse generator on C8M, async reset.

## Test plan
- Stash LEN=3, CADDR=C000, RADDR=000100, C64 bytes 11/22/33 → WRCMD at A=000100..000102 in slots 2..4; EOB=1; CCUR=C003.
- Fetch LEN=2, FIXC=1, REU 5A/A5 → two C64 writes to D020, CDO=5A then A5; RCUR advances by 2.
- Swap LEN=1, C64=AA, REU=55 → C64 gets 55, REU gets AA, 2 slots.
- Verify LEN=4, mismatch at byte 2 → FAULT=1 after slot 3, no slot-4 RDCMD, LCUR=2.
- RADDR=FFFFFF, LEN=2, stash → second write at A=000000; LEN=0 → BUSY for 65537 slots.
- BA low for 3 slots mid-fetch → commands paused, counters frozen, resumed byte correct; nRESET pulse mid-swap → all outputs at reset values immediately.
